// File: rtl/neuron_mac_sequencer.sv
// neuron_mac_sequencer
//
// Computes one neuron pre-activation, bias + sum(x_i * w_i), by sequencing a
// single shared sign-magnitude fixed-point multiplier that sits outside this
// block. (x, w) pairs arrive over a valid/ready handshake and are forwarded
// combinationally to the multiplier. The product comes back one cycle later
// and is added into a wide two's-complement accumulator. The final sum is
// saturated back to sign-magnitude and offered over a second valid/ready
// handshake.
//
// Ports
//   i_clk          clock, all state on the rising edge
//   i_rstn         asynchronous active-low reset
//   i_start        begin a new neuron (sampled only while idle)
//   i_bias         sign-magnitude bias, captured on an accepted start
//   i_in_valid     input pair valid
//   o_in_ready     input pair accepted when i_in_valid & o_in_ready
//   i_in_x, i_in_w sign-magnitude operands
//   i_in_last      final pair of the vector
//   o_mul_a/b      multiplier operands (combinational copies of x/w)
//   i_mul_prod     multiplier product, one cycle after the operands
//   i_mul_ovf      multiplier overflow, aligned with i_mul_prod
//   o_out_valid    result valid, held until taken
//   i_out_ready    consumer ready
//   o_out_sum      saturated sign-magnitude result
//   o_out_sat      result saturated, or a multiplier overflow was seen
//   o_busy         sequencer not idle

module neuron_mac_sequencer #(
  parameter int N               = 16,
  parameter int FRACTIONAL_BITS = 13,
  parameter int MAX_INPUTS      = 8
) (
  input  logic         i_clk,
  input  logic         i_rstn,
  input  logic         i_start,
  input  logic [N-1:0] i_bias,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  input  logic [N-1:0] i_in_x,
  input  logic [N-1:0] i_in_w,
  input  logic         i_in_last,
  output logic [N-1:0] o_mul_a,
  output logic [N-1:0] o_mul_b,
  input  logic [N-1:0] i_mul_prod,
  input  logic         i_mul_ovf,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [N-1:0] o_out_sum,
  output logic         o_out_sat,
  output logic         o_busy
);

  // Addition does not depend on where the binary point sits, so the fraction
  // width only has to leave room for the sign and at least one integer bit.
  if (FRACTIONAL_BITS < 0 || FRACTIONAL_BITS > N - 2) begin : g_bad_fraction
    $error("neuron_mac_sequencer: FRACTIONAL_BITS out of range");
  end

  localparam int CNT_W = $clog2(MAX_INPUTS + 1);
  localparam int ACC_W = N + 1 + CNT_W;
  localparam int MAG_W = N - 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                   r_state;
  logic signed [ACC_W-1:0]  r_acc;
  logic [CNT_W-1:0]         r_count;
  logic                     r_pend;
  logic                     r_sat;
  logic                     r_in_ready;
  logic                     r_out_valid;
  logic                     r_busy;
  logic [N-1:0]             r_out_sum;
  logic                     r_out_sat;

  logic signed [ACC_W-1:0]  w_prod;
  logic signed [ACC_W-1:0]  w_sum;
  logic                     w_sat_acc;
  logic                     w_hs;
  logic [CNT_W-1:0]         w_count_inc;
  logic                     w_end;
  logic                     w_neg;
  logic [ACC_W-1:0]         w_abs;
  logic                     w_ovr;
  logic [N-1:0]             w_res;

  // Sign-magnitude to accumulator width; -0 naturally becomes 0.
  function automatic logic signed [ACC_W-1:0] smToAcc(input logic [N-1:0] v);
    logic signed [ACC_W-1:0] mag;
    mag = {{(ACC_W - MAG_W){1'b0}}, v[N-2:0]};
    return v[N-1] ? -mag : mag;
  endfunction

  assign o_mul_a = i_in_x;
  assign o_mul_b = i_in_w;

  assign w_hs        = r_in_ready & i_in_valid;
  assign w_count_inc = r_count + 1'b1;
  assign w_end       = i_in_last | (w_count_inc == CNT_W'(MAX_INPUTS));

  // The product only belongs to this neuron when a handshake happened on the
  // previous edge; otherwise whatever the multiplier shows is ignored.
  assign w_prod    = smToAcc(i_mul_prod);
  assign w_sum     = r_acc + (r_pend ? w_prod : '0);
  assign w_sat_acc = r_sat | (r_pend & i_mul_ovf);

  // Magnitude of the final sum; anything above the N-1 bit magnitude clamps.
  assign w_neg = w_sum[ACC_W-1];
  assign w_abs = w_neg ? $unsigned(-w_sum) : $unsigned(w_sum);
  assign w_ovr = |w_abs[ACC_W-1:MAG_W];

  always_comb begin
    w_res = '0;
    if (w_ovr) begin
      w_res = {w_neg, {MAG_W{1'b1}}};
    end else if (w_abs[MAG_W-1:0] != '0) begin
      w_res = {w_neg, w_abs[MAG_W-1:0]};
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_count     <= '0;
      r_pend      <= 1'b0;
      r_sat       <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_out_sum   <= '0;
      r_out_sat   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_acc      <= smToAcc(i_bias);
            r_count    <= '0;
            r_sat      <= 1'b0;
            r_pend     <= 1'b0;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= S_ACCUM;
          end
        end

        S_ACCUM: begin
          r_acc  <= w_sum;
          r_sat  <= w_sat_acc;
          r_pend <= w_hs;
          if (w_hs) begin
            r_count <= w_count_inc;
            if (w_end) begin
              r_in_ready <= 1'b0;
              r_state    <= S_DRAIN;
            end
          end
        end

        // Entered only through a handshake, so the last product is pending.
        S_DRAIN: begin
          r_acc       <= w_sum;
          r_sat       <= w_sat_acc;
          r_pend      <= 1'b0;
          r_out_sum   <= w_res;
          r_out_sat   <= w_sat_acc | w_ovr;
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end

        S_DONE: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_out_sum   = r_out_sum;
  assign o_out_sat   = r_out_sat;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_neuron_mac_sequencer.sv
// Testbench for neuron_mac_sequencer: table of directed neurons with
// hand-computed results, plus hand-written sequences for backpressure,
// input gaps and a reset in the middle of accumulation. A behavioural
// Q2.13 sign-magnitude multiplier with one cycle of latency stands in for
// the shared multiplier.

module tb_neuron_mac_sequencer;

  typedef logic [7:0][15:0] pairs_t;

  typedef struct {
    logic [15:0] bias;
    int          nPairs;
    pairs_t      xs;
    pairs_t      ws;
    bit          useLast;
    bit          offerExtra;
    logic [15:0] expSum;
    bit          expSat;
  } vec_t;

  logic        clk;
  logic        rstn;
  logic        start;
  logic [15:0] bias;
  logic        inValid;
  logic        inReady;
  logic [15:0] inX;
  logic [15:0] inW;
  logic        inLast;
  logic [15:0] mulA;
  logic [15:0] mulB;
  logic [15:0] mulProd;
  logic        mulOvf;
  logic        outValid;
  logic        outReady;
  logic [15:0] outSum;
  logic        outSat;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  neuron_mac_sequencer #(
    .N(16),
    .FRACTIONAL_BITS(13),
    .MAX_INPUTS(8)
  ) dut (
    .i_clk(clk),
    .i_rstn(rstn),
    .i_start(start),
    .i_bias(bias),
    .i_in_valid(inValid),
    .o_in_ready(inReady),
    .i_in_x(inX),
    .i_in_w(inW),
    .i_in_last(inLast),
    .o_mul_a(mulA),
    .o_mul_b(mulB),
    .i_mul_prod(mulProd),
    .i_mul_ovf(mulOvf),
    .o_out_valid(outValid),
    .i_out_ready(outReady),
    .o_out_sum(outSum),
    .o_out_sat(outSat),
    .o_busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Q2.13 sign-magnitude multiply, magnitude clamped with an overflow flag.
  function automatic logic [16:0] mulModel(input logic [15:0] a, input logic [15:0] b);
    logic [31:0] mag;
    logic        ovf;
    mag = ({17'd0, a[14:0]} * {17'd0, b[14:0]}) >> 13;
    ovf = (mag > 32'd32767);
    if (ovf) mag = 32'd32767;
    return {ovf, (mag == 0) ? 1'b0 : (a[15] ^ b[15]), mag[14:0]};
  endfunction

  always @(posedge clk) {mulOvf, mulProd} <= mulModel(mulA, mulB);

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  function automatic vec_t mkVec(input logic [15:0] b, input int n, input pairs_t xs, input pairs_t ws,
                                 input bit useLast, input bit extra, input logic [15:0] es, input bit esat);
    vec_t v;
    v.bias = b; v.nPairs = n; v.xs = xs; v.ws = ws;
    v.useLast = useLast; v.offerExtra = extra; v.expSum = es; v.expSat = esat;
    return v;
  endfunction

  // Runs one neuron. gapMax adds random idle cycles before each pair; with
  // holdCycles=0 out_ready is already high when out_valid rises.
  task automatic applyStimulus(input vec_t v, input int gapMax, input int holdCycles);
    int startEdge;
    int lastEdge;
    int waited;
    int gaps;
    outReady = (holdCycles == 0);
    start = 1'b1;
    bias  = v.bias;
    tick();
    start = 1'b0;
    startEdge = cycle;
    checkOutput("inReadyAfterStart", {31'd0, inReady}, 32'd1);
    for (int i = 0; i < v.nPairs; i++) begin
      gaps = (gapMax > 0) ? int'($urandom_range(0, gapMax)) : 0;
      inValid = 1'b0;
      repeat (gaps) tick();
      inValid = 1'b1;
      inX     = v.xs[i];
      inW     = v.ws[i];
      inLast  = v.useLast && (i == v.nPairs - 1);
      #1;
      checkOutput("mulOperands", {mulA, mulB}, {v.xs[i], v.ws[i]});
      waited = 0;
      while (!inReady && waited < 20) begin
        tick();
        waited++;
      end
      checkOutput("inReadyForPair", {31'd0, inReady}, 32'd1);
      tick();
    end
    lastEdge = cycle;
    inValid = 1'b0;
    inLast  = 1'b0;
    checkOutput("inReadyAfterLast", {31'd0, inReady}, 32'd0);
    checkOutput("validNotEarly", {31'd0, outValid}, 32'd0);
    if (v.offerExtra) begin
      inValid = 1'b1;
      inX = 16'h2000;
      inW = 16'h2000;
      tick();
      inValid = 1'b0;
    end
    waited = 0;
    while (!outValid && waited < 20) begin
      tick();
      waited++;
    end
    checkOutput("lastToValidEdges", cycle - lastEdge, 32'd1);
    if (gapMax == 0) checkOutput("startToValidEdges", cycle - startEdge, v.nPairs + 1);
    checkOutput("outSum", {16'd0, outSum}, {16'd0, v.expSum});
    checkOutput("outSat", {31'd0, outSat}, {31'd0, v.expSat});
    for (int h = 0; h < holdCycles; h++) begin
      start = 1'b1;
      tick();
      checkOutput("holdValid", {31'd0, outValid}, 32'd1);
      checkOutput("holdSum", {16'd0, outSum}, {16'd0, v.expSum});
      checkOutput("holdSat", {31'd0, outSat}, {31'd0, v.expSat});
      checkOutput("holdInReady", {31'd0, inReady}, 32'd0);
      checkOutput("holdBusy", {31'd0, busy}, 32'd1);
    end
    start = 1'b0;
    outReady = 1'b1;
    tick();
    checkOutput("validDropped", {31'd0, outValid}, 32'd0);
    checkOutput("idleBusy", {31'd0, busy}, 32'd0);
    checkOutput("idleInReady", {31'd0, inReady}, 32'd0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "InReady"}, {31'd0, inReady}, 32'd0);
    checkOutput({tag, "OutValid"}, {31'd0, outValid}, 32'd0);
    checkOutput({tag, "OutSum"}, {16'd0, outSum}, 32'd0);
    checkOutput({tag, "OutSat"}, {31'd0, outSat}, 32'd0);
    checkOutput({tag, "Busy"}, {31'd0, busy}, 32'd0);
  endtask

  vec_t tbl[$];
  int   sawValid;

  initial begin
    rstn = 1'b0; start = 1'b0; bias = '0; inValid = 1'b0; inX = '0; inW = '0;
    inLast = 1'b0; outReady = 1'b1;

    // Pairs are packed last-pair-first, so the rightmost literal is pair 0.
    tbl.push_back(mkVec(16'h0000, 2, pairs_t'({16'h3000, 16'h2000}), pairs_t'({16'h9000, 16'h2000}), 1, 0, 16'h0800, 0));
    tbl.push_back(mkVec(16'h8800, 1, pairs_t'(16'h2000), pairs_t'(16'hA000), 1, 0, 16'hA800, 0));
    tbl.push_back(mkVec(16'h8000, 1, pairs_t'(16'h0000), pairs_t'(16'h2000), 1, 0, 16'h0000, 0));
    tbl.push_back(mkVec(16'h6000, 1, pairs_t'(16'h2000), pairs_t'(16'h3000), 1, 0, 16'h7FFF, 1));
    tbl.push_back(mkVec(16'hE000, 1, pairs_t'(16'h2000), pairs_t'(16'hB000), 1, 0, 16'hFFFF, 1));
    tbl.push_back(mkVec(16'hFFFF, 1, pairs_t'(16'h7FFF), pairs_t'(16'h7FFF), 1, 0, 16'h0000, 1));
    tbl.push_back(mkVec(16'h0000, 1, pairs_t'(16'h1000), pairs_t'(16'h2000), 1, 0, 16'h1000, 0));
    tbl.push_back(mkVec(16'h0000, 8, pairs_t'({8{16'h2000}}), pairs_t'({8{16'h0400}}), 0, 1, 16'h2000, 0));
    tbl.push_back(mkVec(16'h0100, 3, pairs_t'({16'h4000, 16'hA000, 16'hA000}),
                        pairs_t'({16'h8400, 16'hA000, 16'h2000}), 1, 0, 16'h8700, 0));
    tbl.push_back(mkVec(16'h7000, 1, pairs_t'(16'h2000), pairs_t'(16'h0FFF), 1, 0, 16'h7FFF, 0));

    repeat (3) tick();
    checkResetOutputs("reset");
    rstn = 1'b1;
    tick();
    checkOutput("idleAfterReset", {31'd0, busy}, 32'd0);

    foreach (tbl[k]) applyStimulus(tbl[k], 0, 0);

    $display("[TB] gapped input stream");
    applyStimulus(tbl[8], 2, 0);
    applyStimulus(tbl[0], 3, 0);

    $display("[TB] output backpressure");
    applyStimulus(tbl[0], 0, 5);

    $display("[TB] reset in the middle of accumulation");
    start = 1'b1;
    bias  = 16'h1000;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      inValid = 1'b1;
      inX = 16'h2000;
      inW = 16'h2000;
      tick();
    end
    inValid = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    checkResetOutputs("midReset");
    #2;
    rstn = 1'b1;
    sawValid = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (outValid) sawValid = 1;
    end
    checkOutput("noValidAfterReset", sawValid, 32'd0);
    checkOutput("idleAfterMidReset", {31'd0, busy}, 32'd0);
    applyStimulus(tbl[1], 0, 0);
    applyStimulus(tbl[7], 0, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
